// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types and Funct3 encodings for the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned variants exist only for loads.
    function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (is_load) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Byte-lane enables, store replication and load extension.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wd,
    input  logic [31:0] i_mem_rd,
    output logic [3:0]  o_we,
    output logic [31:0] o_wd_rep,
    output logic [31:0] o_rd_ext
);

    logic [31:0] w_shifted;

    assign w_shifted = i_mem_rd >> {i_addr_lo, 3'b000};

    always_comb begin
        o_we     = 4'b1111;
        o_wd_rep = i_wd;
        case (i_funct3[1:0])
            2'b00: begin
                o_we     = 4'b0001 << i_addr_lo;
                o_wd_rep = {4{i_wd[7:0]}};
            end
            2'b01: begin
                o_we     = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_wd_rep = {2{i_wd[15:0]}};
            end
            default: begin
                o_we     = 4'b1111;
                o_wd_rep = i_wd;
            end
        endcase
    end

    always_comb begin
        o_rd_ext = w_shifted;
        case (i_funct3)
            F3_B:    o_rd_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_BU:   o_rd_ext = {24'd0, w_shifted[7:0]};
            F3_H:    o_rd_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_HU:   o_rd_ext = {16'd0, w_shifted[15:0]};
            default: o_rd_ext = w_shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ctrl
// Description : Load/store sequencer between EX/MEM and the data memory.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int DM_ADDRESS  = 9,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [DATA_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wd,
    input  logic [2:0]            Funct3,
    output logic [DM_ADDRESS-1:0] mem_a,
    output logic                  mem_re,
    output logic [3:0]            mem_we,
    output logic [DATA_W-1:0]     mem_wd,
    input  logic [DATA_W-1:0]     mem_rd,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rd,
    output logic                  misaligned,
    output logic                  illegal,
    output logic                  stall
);

    // WAIT holds for MEM_LATENCY-1 cycles; counter counts down to zero.
    localparam logic [2:0] c_WAIT_INIT = (MEM_LATENCY > 1) ? 3'(MEM_LATENCY - 2) : 3'd0;

    lsu_state_e              r_state;
    lsu_state_e              w_next;
    logic                    w_accept;
    logic                    w_illegal;
    logic                    w_misaligned;
    logic                    r_is_load;
    logic [2:0]              r_funct3;
    logic [1:0]              r_addr_lo;
    logic [DM_ADDRESS-3:0]   r_word_addr;
    logic [DATA_W-1:0]       r_wd;
    logic [2:0]              r_cnt;
    logic [DATA_W-1:0]       r_rd;
    logic                    r_misaligned;
    logic                    r_illegal;
    logic [3:0]              w_we;
    logic [DATA_W-1:0]       w_wd_rep;
    logic [DATA_W-1:0]       w_rd_ext;
    logic                    w_unused;

    assign w_unused = ^{addr[DATA_W-1:DM_ADDRESS]};

    assign w_accept     = req_valid && (r_state == IDLE) && (MemRead || MemWrite);
    assign w_illegal    = (MemRead && MemWrite) || !f3_legal(MemRead, Funct3);
    assign w_misaligned = !w_illegal &&
                          (((Funct3[1:0] == 2'b01) && addr[0]) ||
                           ((Funct3 == F3_W) && (addr[1:0] != 2'b00)));

    lsu_align u_align (
        .i_funct3  (r_funct3),
        .i_addr_lo (r_addr_lo),
        .i_wd      (r_wd),
        .i_mem_rd  (mem_rd),
        .o_we      (w_we),
        .o_wd_rep  (w_wd_rep),
        .o_rd_ext  (w_rd_ext)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 4'b0000;
        rsp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (w_accept) begin
                    w_next = (w_illegal || w_misaligned) ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                mem_re = r_is_load;
                mem_we = r_is_load ? 4'b0000 : w_we;
                w_next = (r_is_load && (MEM_LATENCY > 1)) ? WAIT : RESP;
            end
            WAIT: begin
                if (r_cnt == 3'd0) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_is_load    <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr_lo    <= 2'b00;
            r_word_addr  <= '0;
            r_wd         <= '0;
            r_cnt        <= 3'd0;
            r_rd         <= '0;
            r_misaligned <= 1'b0;
            r_illegal    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_is_load    <= MemRead;
                r_funct3     <= Funct3;
                r_addr_lo    <= addr[1:0];
                r_word_addr  <= addr[DM_ADDRESS-1:2];
                r_wd         <= wd;
                r_misaligned <= w_misaligned;
                r_illegal    <= w_illegal;
            end
            if (r_state == ISSUE) begin
                r_cnt <= c_WAIT_INIT;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - 3'd1;
            end
            // Fault responses bypass ISSUE/WAIT, so rd is untouched for them.
            if (r_is_load && (w_next == RESP) &&
                ((r_state == ISSUE) || (r_state == WAIT))) begin
                r_rd <= w_rd_ext;
            end
        end
    end

    assign mem_a      = {r_word_addr, 2'b00};
    assign mem_wd     = w_wd_rep;
    assign rd         = r_rd;
    assign misaligned = r_misaligned;
    assign illegal    = r_illegal;
    assign stall      = !req_ready;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_ctrl
// Description : Directed bench for lsu_ctrl at MEM_LATENCY 1 and 3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_ctrl;
    import lsu_pkg::*;

    localparam int c_DMA = 9;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_valid3 = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wd = '0;
    logic [2:0]  Funct3 = 3'b000;
    logic [31:0] mem_rd = '0;

    logic             req_ready, mem_re, rsp_valid, misaligned, illegal, stall;
    logic [c_DMA-1:0] mem_a;
    logic [3:0]       mem_we;
    logic [31:0]      mem_wd, rd;

    logic             req_ready3, mem_re3, rsp_valid3, misaligned3, illegal3, stall3;
    logic [c_DMA-1:0] mem_a3;
    logic [3:0]       mem_we3;
    logic [31:0]      mem_wd3, rd3;

    int n_vec = 0;
    int n_err = 0;

    lsu_ctrl #(.DM_ADDRESS(c_DMA), .DATA_W(32), .MEM_LATENCY(1)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .MemRead(MemRead), .MemWrite(MemWrite), .addr(addr), .wd(wd), .Funct3(Funct3),
        .mem_a(mem_a), .mem_re(mem_re), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .rsp_valid(rsp_valid), .rd(rd), .misaligned(misaligned), .illegal(illegal),
        .stall(stall)
    );

    lsu_ctrl #(.DM_ADDRESS(c_DMA), .DATA_W(32), .MEM_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset), .req_valid(req_valid3), .req_ready(req_ready3),
        .MemRead(MemRead), .MemWrite(MemWrite), .addr(addr), .wd(wd), .Funct3(Funct3),
        .mem_a(mem_a3), .mem_re(mem_re3), .mem_we(mem_we3), .mem_wd(mem_wd3), .mem_rd(mem_rd),
        .rsp_valid(rsp_valid3), .rd(rd3), .misaligned(misaligned3), .illegal(illegal3),
        .stall(stall3)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one request for a single cycle; returns in the cycle after accept.
    task automatic req(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input logic to3);
        MemRead  = ld;
        MemWrite = st;
        Funct3   = f3;
        addr     = a;
        wd       = d;
        if (to3) req_valid3 = 1'b1;
        else     req_valid  = 1'b1;
        tick();
        req_valid  = 1'b0;
        req_valid3 = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_rsp", 32'(rsp_valid), 32'd0);
        chk("rst_re", 32'(mem_re), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_a", 32'(mem_a), 32'd0);
        chk("rst_wd", mem_wd, 32'd0);
        chk("rst_rd", rd, 32'd0);
        chk("rst_flags", 32'({misaligned, illegal}), 32'd0);
        reset = 1'b0;

        // SB to byte lane 2
        req(1'b0, 1'b1, F3_B, 32'h0000_0006, 32'h1234_56A7, 1'b0);
        chk("sb_a", 32'(mem_a), 32'h004);
        chk("sb_we", 32'(mem_we), 32'b0100);
        chk("sb_wd", mem_wd, 32'hA7A7_A7A7);
        chk("sb_re", 32'(mem_re), 32'd0);
        chk("sb_stall", 32'(stall), 32'd1);
        tick();
        chk("sb_rsp", 32'(rsp_valid), 32'd1);
        chk("sb_mis", 32'(misaligned), 32'd0);
        chk("sb_we_off", 32'(mem_we), 32'd0);
        tick();
        chk("sb_idle_rsp", 32'(rsp_valid), 32'd0);
        chk("sb_idle_ready", 32'(req_ready), 32'd1);

        mem_rd = 32'h8000_0000;
        req(1'b1, 1'b0, F3_B, 32'h0000_0007, 32'h0, 1'b0);
        chk("lb_re", 32'(mem_re), 32'd1);
        chk("lb_we", 32'(mem_we), 32'd0);
        tick();
        chk("lb_rsp", 32'(rsp_valid), 32'd1);
        chk("lb_rd", rd, 32'hFFFF_FF80);
        tick();
        req(1'b1, 1'b0, F3_BU, 32'h0000_0007, 32'h0, 1'b0);
        tick();
        chk("lbu_rd", rd, 32'h0000_0080);
        tick();

        mem_rd = 32'h9ABC_1234;
        req(1'b1, 1'b0, F3_H, 32'h0000_0002, 32'h0, 1'b0);
        tick();
        chk("lh_rd", rd, 32'hFFFF_9ABC);
        tick();
        req(1'b1, 1'b0, F3_HU, 32'h0000_0002, 32'h0, 1'b0);
        tick();
        chk("lhu_rd", rd, 32'h0000_9ABC);
        tick();
        req(1'b1, 1'b0, F3_W, 32'h0000_0000, 32'h0, 1'b0);
        tick();
        chk("lw_rd", rd, 32'h9ABC_1234);
        tick();

        // Misaligned word: fast fault response, rd untouched
        mem_rd = 32'h0;
        req(1'b1, 1'b0, F3_W, 32'h0000_0006, 32'h0, 1'b0);
        chk("mis_rsp", 32'(rsp_valid), 32'd1);
        chk("mis_flag", 32'(misaligned), 32'd1);
        chk("mis_ill", 32'(illegal), 32'd0);
        chk("mis_re", 32'(mem_re), 32'd0);
        chk("mis_rd", rd, 32'h9ABC_1234);
        tick();
        chk("mis_idle", 32'(req_ready), 32'd1);

        req(1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'h0, 1'b0);
        chk("ill_rsp", 32'(rsp_valid), 32'd1);
        chk("ill_flag", 32'(illegal), 32'd1);
        chk("ill_mis", 32'(misaligned), 32'd0);
        tick();

        req(1'b1, 1'b1, F3_W, 32'h0000_0000, 32'h0, 1'b0);
        chk("rw_ill", 32'(illegal), 32'd1);
        chk("rw_we", 32'(mem_we), 32'd0);
        chk("rw_re", 32'(mem_re), 32'd0);
        tick();

        req(1'b1, 1'b0, F3_H, 32'h0000_0003, 32'h0, 1'b0);
        chk("mish_flag", 32'({misaligned, illegal}), 32'b10);
        tick();

        // Neither MemRead nor MemWrite: ignored
        req(1'b0, 1'b0, F3_W, 32'h0000_0000, 32'h0, 1'b0);
        chk("nop_ready", 32'(req_ready), 32'd1);
        tick();
        chk("nop_rsp", 32'(rsp_valid), 32'd0);

        req(1'b0, 1'b1, F3_H, 32'h0000_0002, 32'hDEAD_BEEF, 1'b0);
        chk("sh_we", 32'(mem_we), 32'b1100);
        chk("sh_wd", mem_wd, 32'hBEEF_BEEF);
        tick();
        chk("sh_mis_clr", 32'({misaligned, illegal}), 32'd0);
        tick();

        // Address bits above DM_ADDRESS are dropped
        mem_rd = 32'h1122_3344;
        req(1'b1, 1'b0, F3_W, 32'hFFFF_F204, 32'h0, 1'b0);
        chk("hi_a", 32'(mem_a), 32'h004);
        tick();
        chk("hi_rd", rd, 32'h1122_3344);
        chk("hi_flags", 32'({misaligned, illegal}), 32'd0);
        tick();

        // MEM_LATENCY = 3 instance
        mem_rd = 32'h55AA_00FF;
        chk("l3_ready0", 32'(req_ready3), 32'd1);
        req(1'b1, 1'b0, F3_W, 32'h0000_0010, 32'h0, 1'b1);
        chk("l3_c1_re", 32'(mem_re3), 32'd1);
        chk("l3_c1_stall", 32'(stall3), 32'd1);
        chk("l3_c1_a", 32'(mem_a3), 32'h010);
        tick();
        chk("l3_c2", 32'({mem_re3, stall3, rsp_valid3}), 32'b010);
        tick();
        chk("l3_c3", 32'({mem_re3, stall3, rsp_valid3}), 32'b010);
        tick();
        chk("l3_c4", 32'({mem_re3, stall3, rsp_valid3}), 32'b011);
        chk("l3_rd", rd3, 32'h55AA_00FF);
        tick();
        chk("l3_c5_ready", 32'(req_ready3), 32'd1);
        chk("l3_c5_rsp", 32'(rsp_valid3), 32'd0);

        // Reset during WAIT aborts the load
        mem_rd = 32'h0BAD_F00D;
        req(1'b1, 1'b0, F3_W, 32'h0000_0020, 32'h0, 1'b1);
        tick();
        chk("ab_wait", 32'({stall3, rsp_valid3}), 32'b10);
        reset = 1'b1;
        tick();
        chk("ab_ready", 32'(req_ready3), 32'd1);
        chk("ab_rsp", 32'(rsp_valid3), 32'd0);
        chk("ab_rd", rd3, 32'd0);
        reset = 1'b0;
        tick();
        chk("ab_rsp2", 32'({rsp_valid3, mem_we3}), 32'd0);
        tick();
        chk("ab_rsp3", 32'({rsp_valid3, mem_we3}), 32'd0);

        req(1'b0, 1'b1, F3_W, 32'h0000_0008, 32'hCAFE_F00D, 1'b1);
        chk("sw_we", 32'(mem_we3), 32'b1111);
        chk("sw_wd", mem_wd3, 32'hCAFE_F00D);
        chk("sw_a", 32'(mem_a3), 32'h008);
        tick();
        chk("sw_we_off", 32'(mem_we3), 32'd0);
        chk("sw_rsp", 32'(rsp_valid3), 32'd1);
        tick();
        chk("sw_ready", 32'({req_ready3, rsp_valid3}), 32'b10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store sequencing stage directly upstream of the data memory. Sits between the EX/MEM pipeline boundary and the data memory array.
- Accepts one memory request per handshake and checks alignment and Funct3 legality.
- Generates byte-lane write enables and replicated store data, issues the memory access and waits a fixed latency.
- Returns aligned, sign/zero-extended load data and stalls the pipeline while busy.

Parameters:
- DM_ADDRESS, 9, data memory byte-address width driven on mem_a
- DATA_W, 32, data width (fixed at 32 for lane logic)
- MEM_LATENCY, 1, cycles from mem_re assertion to valid mem_rd (1..4)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present from MEM stage
- req_ready  out  1  block can accept a request this cycle
- MemRead  in  1  request is a load
- MemWrite  in  1  request is a store
- addr  in  DATA_W  byte address (ALU result)
- wd  in  DATA_W  store data (rs2)
- Funct3  in  3  instruction bits 14:12
- mem_a  out  DM_ADDRESS  word-aligned address to memory
- mem_re  out  1  memory read strobe
- mem_we  out  4  per-byte write enables
- mem_wd  out  DATA_W  lane-replicated store data
- mem_rd  in  DATA_W  raw word from memory
- rsp_valid  out  1  one-cycle pulse: request completed
- rd  out  DATA_W  extended load data, held until next rsp_valid
- misaligned  out  1  valid with rsp_valid; access was misaligned
- illegal  out  1  valid with rsp_valid; bad Funct3 or MemRead&MemWrite
- stall  out  1  pipeline hold, equals !req_ready

Behaviour:
- Reset: state IDLE; req_ready=1; stall=0; rsp_valid=0; mem_re=0; mem_we=0; mem_a=0; mem_wd=0; rd=0; misaligned=0; illegal=0.
- Reset mid-operation: return to IDLE next edge. No write enable is issued after reset and no rsp_valid is produced for the aborted request.
- Handshake: a request is accepted when req_valid && req_ready && (MemRead || MemWrite). With neither asserted the request is ignored and req_ready stays 1. Request fields are registered on accept.
- States:
  - IDLE: on accept, go to ISSUE, or to RESP if the request is misaligned or illegal.
  - ISSUE: drive mem_a and one of mem_re or mem_we for exactly one cycle. A store goes to RESP; a load goes to WAIT.
  - WAIT: count MEM_LATENCY-1 further cycles; go directly to RESP when MEM_LATENCY=1. Sample mem_rd on entry to RESP.
  - RESP: rsp_valid=1 for one cycle, then IDLE.
- req_ready=1 only in IDLE.
- Latency (MEM_LATENCY=1): accept at cycle 0, rsp_valid at cycle 2 for both loads and stores. Fault responses arrive at cycle 1.
- Legal Funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other Funct3, or MemRead && MemWrite, sets illegal=1.
- Misaligned: a halfword with addr[0]=1, or a word with addr[1:0]!=0. Misaligned has priority below illegal.
- Any fault: no mem_re and no mem_we issued; rd unchanged.
- mem_a = {addr[DM_ADDRESS-1:2], 2'b00}. Address bits at and above DM_ADDRESS are ignored, with no fault.
- Stores:
  - SB: mem_we = 4'b0001 << addr[1:0]; mem_wd = {4{wd[7:0]}}.
  - SH: mem_we = 4'b0011 << {addr[1],1'b0}; mem_wd = {2{wd[15:0]}}.
  - SW: mem_we = 4'b1111; mem_wd = wd.
- Loads: shift mem_rd right by 8*addr[1:0] bits, then:
  - LB sign-extends bit 7; LBU zero-extends bit 7.
  - LH sign-extends bit 15; LHU zero-extends bit 15.
  - LW passes the word through.
- misaligned and illegal are registered at accept and cleared when the next request is accepted.

Decomposition:
- Package lsu_pkg holds:
  - state enum lsu_state_e {IDLE, ISSUE, WAIT, RESP};
  - Funct3 constants F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
- One combinational sub-module, lsu_align: byte-lane enable and store replication plus load extraction/extension, given Funct3 and addr[1:0]. The FSM, latency counter and registers stay in lsu_ctrl.

Test Plan:
- SB addr=0x0000_0006 wd=0x1234_56A7 -> ISSUE cycle: mem_a=0x004, mem_we=4'b0100, mem_wd=0xA7A7A7A7; rsp_valid at cycle 2, misaligned=0.
- LB addr=0x007, mem_rd=0x8000_0000 -> rd=0xFFFF_FF80. LBU same stimulus -> rd=0x0000_0080.
- LH addr=0x002 mem_rd=0x9ABC_1234 -> rd=0xFFFF_9ABC. LHU -> rd=0x0000_9ABC. LW addr=0x000 -> rd=0x9ABC_1234.
- LW addr=0x006 -> no mem_re/mem_we, rsp_valid at cycle 1 with misaligned=1. Funct3=3'b011 load -> illegal=1.
- MEM_LATENCY=3: LW accepted at cycle 0 -> mem_re only at cycle 1, stall=1 for cycles 1-4, rsp_valid at cycle 4, req_ready=1 at cycle 5.
- Reset asserted during WAIT of a load, then an SW issued -> no rsp_valid for the load; SW completes normally with mem_we=4'b1111 exactly one cycle.
